// File: rtl/pes_vm_dispenser.sv
// Vending-machine actuator back end: queues product/change requests and runs the
// product motor and coin hoppers with sense confirmation, timeout, retry and sticky fault.
module pes_vm_dispenser #(
   parameter int FIFO_DEPTH = 4,
   parameter int PULSE_LEN  = 4,
   parameter int TIMEOUT    = 64,
   parameter int RETRIES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_out,
   input  logic [1:0] req_change,
   output logic       prod_drive,
   input  logic       prod_sense,
   output logic       coin5_drive,
   input  logic       coin5_sense,
   output logic       coin10_drive,
   input  logic       coin10_sense,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code,
   input  logic       fault_clr
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int TMAX = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
   localparam int TW   = $clog2(TMAX) + 1;
   localparam int RW   = $clog2(RETRIES + 1) + 1;
   localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_LEN - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX    = RW'(RETRIES);
   localparam logic [AW:0]   DEPTH_CNT    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, POP, PROD_DRV, PROD_WAIT, COIN_DRV, COIN_WAIT, DONE, FAULT
   } state_t;

   state_t          state_reg, state_next;
   logic [2:0]      fifo_mem [FIFO_DEPTH];
   logic [2:0]      head_reg;
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic            full, empty, push, pop;
   logic [1:0]      cur_change_reg;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [RW-1:0]   retry_reg, retry_next;
   logic            hit_reg, hit_next;
   logic [1:0]      fault_code_reg, fault_code_next;
   logic [2:0]      sense_in, sense_edge;
   logic            prod_edge, coin_edge;

   // Sense inputs: 2-flop synchronizer plus a third stage for rising-edge detection.
   assign sense_in = {coin10_sense, coin5_sense, prod_sense};
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sense
         logic [2:0] sync_reg;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) sync_reg <= '0;
            else        sync_reg <= {sync_reg[1:0], sense_in[gi]};
         end
         assign sense_edge[gi] = sync_reg[1] & ~sync_reg[2];
      end
   endgenerate

   assign prod_edge = sense_edge[0];
   assign coin_edge = (cur_change_reg == 2'b01) ? sense_edge[1] : sense_edge[2];

   // Request FIFO; head is a registered read of the entry at the read pointer.
   assign full  = (count_reg == DEPTH_CNT);
   assign empty = (count_reg == '0);
   assign push  = req_valid && req_ready;
   assign pop   = (state_reg == POP);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW + 1)'(1);
            2'b01:   count_reg <= count_reg - (AW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_reg] <= {req_out, req_change};
      head_reg <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_reg      <= '0;
         retry_reg      <= '0;
         hit_reg        <= 1'b0;
         fault_code_reg <= 2'b00;
         cur_change_reg <= 2'b00;
      end else begin
         timer_reg      <= timer_next;
         retry_reg      <= retry_next;
         hit_reg        <= hit_next;
         fault_code_reg <= fault_code_next;
         if (pop) cur_change_reg <= head_reg[1:0];
      end
   end

   always_comb begin
      state_next      = state_reg;
      timer_next      = '0;
      retry_next      = retry_reg;
      hit_next        = 1'b0;
      fault_code_next = fault_code_reg;
      case (state_reg)
         IDLE: if (!empty) state_next = POP;
         POP: begin
            retry_next = '0;
            if (head_reg[2])                   state_next = PROD_DRV;
            else if (head_reg[1] ^ head_reg[0]) state_next = COIN_DRV;
            else                               state_next = DONE;
         end
         PROD_DRV: begin
            // An early sense edge is remembered so the wait phase ends at once.
            hit_next   = hit_reg | prod_edge;
            timer_next = timer_reg + TW'(1);
            if (timer_reg == PULSE_LAST) state_next = PROD_WAIT;
         end
         PROD_WAIT: begin
            timer_next = timer_reg + TW'(1);
            if (hit_reg || prod_edge) begin
               if (cur_change_reg[1] ^ cur_change_reg[0]) begin
                  state_next = COIN_DRV;
                  retry_next = '0;
               end else begin
                  state_next = DONE;
               end
            end else if (timer_reg == TIMEOUT_LAST) begin
               if (retry_reg < RETRY_MAX) begin
                  retry_next = retry_reg + RW'(1);
                  state_next = PROD_DRV;
               end else begin
                  state_next      = FAULT;
                  fault_code_next = 2'b01;
               end
            end
         end
         COIN_DRV: begin
            hit_next   = hit_reg | coin_edge;
            timer_next = timer_reg + TW'(1);
            if (timer_reg == PULSE_LAST) state_next = COIN_WAIT;
         end
         COIN_WAIT: begin
            timer_next = timer_reg + TW'(1);
            if (hit_reg || coin_edge) begin
               state_next = DONE;
            end else if (timer_reg == TIMEOUT_LAST) begin
               if (retry_reg < RETRY_MAX) begin
                  retry_next = retry_reg + RW'(1);
                  state_next = COIN_DRV;
               end else begin
                  state_next      = FAULT;
                  fault_code_next = (cur_change_reg == 2'b01) ? 2'b10 : 2'b11;
               end
            end
         end
         DONE: state_next = IDLE;
         FAULT: begin
            if (fault_clr) begin
               state_next      = IDLE;
               fault_code_next = 2'b00;
            end
         end
         default: state_next = IDLE;
      endcase
      if (state_next != state_reg) timer_next = '0;
   end

   assign prod_drive   = (state_reg == PROD_DRV);
   assign coin5_drive  = (state_reg == COIN_DRV) && (cur_change_reg == 2'b01);
   assign coin10_drive = (state_reg == COIN_DRV) && (cur_change_reg == 2'b10);
   assign done         = (state_reg == DONE);
   assign fault        = (state_reg == FAULT);
   assign fault_code   = fault_code_reg;
   assign busy         = (state_reg != IDLE) || !empty;
   assign req_ready    = !full && (state_reg != FAULT);
endmodule

// File: tb/tb_pes_vm_dispenser.sv
// Bench for pes_vm_dispenser: transaction-level model plus directed scenarios
// with hand-computed latencies.
module tb_pes_vm_dispenser;
   localparam int FIFO_DEPTH = 4;
   localparam int PULSE_LEN  = 4;
   localparam int TIMEOUT    = 64;
   localparam int RETRIES    = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_out = 1'b0;
   logic [1:0] req_change = 2'b00;
   logic       prod_drive, coin5_drive, coin10_drive;
   logic       busy, done, fault;
   logic [1:0] fault_code;
   logic       fault_clr = 1'b0;
   wire  [2:0] sense_w;
   wire  [2:0] drv = {coin10_drive, coin5_drive, prod_drive};

   always #5 clock = ~clock;

   pes_vm_dispenser #(
      .FIFO_DEPTH(FIFO_DEPTH), .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_out(req_out), .req_change(req_change),
      .prod_drive(prod_drive), .prod_sense(sense_w[0]),
      .coin5_drive(coin5_drive), .coin5_sense(sense_w[1]),
      .coin10_drive(coin10_drive), .coin10_sense(sense_w[2]),
      .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
      .fault_clr(fault_clr)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sense responders: pulse a sensor resp_dly cycles after its drive falls,
   // from attempt resp_k onward (0 = never answer).
   int resp_k[3] = '{0, 0, 0};
   int resp_dly = 10;
   for (genvar gi = 0; gi < 3; gi++) begin : g_resp
      logic s;
      assign sense_w[gi] = s;
      initial begin
         int att;
         logic prev;
         s = 1'b0;
         att = 0;
         prev = 1'b0;
         forever begin
            @(negedge clock);
            if (!reset || done) att = 0;
            if (prev && !drv[gi]) begin
               att++;
               if (resp_k[gi] != 0 && att >= resp_k[gi]) begin
                  repeat (resp_dly) @(negedge clock);
                  s = 1'b1;
                  repeat (2) @(negedge clock);
                  s = 1'b0;
               end
            end
            prev = drv[gi];
         end
      end
   end

   // Transaction model: queue of accepted requests, head is the one in service.
   logic [2:0] mq[$];
   logic [2:0] done_log[$];
   logic [2:0] h;
   int  run_len[3] = '{0, 0, 0};
   int  rise_cnt[3] = '{0, 0, 0};
   int  last_rise[3] = '{0, 0, 0};
   logic [2:0] drv_prev = 3'b000;
   logic fault_prev = 1'b0, done_prev = 1'b0;
   logic [1:0] exp_code = 2'b00;
   int  n_prod = 0, n_coin = 0, since_fall = 0;
   int  done_cnt = 0, last_done = 0, last_fault = 0, last_acc = 0;

   always @(negedge clock) begin
      if (!reset) begin
         mq.delete();
         run_len = '{0, 0, 0};
         drv_prev = 3'b000;
         fault_prev = 1'b0;
         done_prev = 1'b0;
         n_prod = 0;
         n_coin = 0;
         since_fall = 0;
      end else begin
         since_fall++;
         if (fault_prev && !fault) begin
            chk("fault_clr_no_done", done, 0);
            if (mq.size() > 0) void'(mq.pop_front());
            n_prod = 0;
            n_coin = 0;
         end
         chk("one_drive_max", $countones(drv) <= 1, 1);
         chk("busy", busy, mq.size() != 0);
         if (fault) begin
            chk("drive_in_fault", drv, 0);
            chk("ready_in_fault", req_ready, 0);
         end else if (mq.size() < FIFO_DEPTH) chk("ready_space", req_ready, 1);
         else if (mq.size() > FIFO_DEPTH)  chk("ready_full", req_ready, 0);
         if (fault && !fault_prev) begin
            last_fault = cyc;
            chk("fault_has_req", mq.size() > 0, 1);
            if (n_coin > 0) begin
               exp_code = (mq.size() > 0 && mq[0][1:0] == 2'b01) ? 2'd2 : 2'd3;
               chk("fault_attempts", n_coin, RETRIES + 1);
            end else begin
               exp_code = 2'd1;
               chk("fault_attempts", n_prod, RETRIES + 1);
            end
            chk("fault_after_timeout", since_fall, TIMEOUT);
         end
         chk("fault_code", fault_code, fault ? exp_code : 2'd0);
         for (int i = 0; i < 3; i++) begin
            if (drv[i]) run_len[i]++;
            if (drv[i] && !drv_prev[i]) begin
               rise_cnt[i]++;
               last_rise[i] = cyc;
               chk("drive_has_req", mq.size() > 0, 1);
               if (mq.size() > 0) begin
                  if (i == 0) begin
                     chk("prod_wanted", mq[0][2], 1);
                     chk("prod_before_coin", n_coin, 0);
                     n_prod++;
                     if (n_prod > 1) chk("prod_retry_gap", since_fall, TIMEOUT);
                     chk("prod_attempt_limit", n_prod <= RETRIES + 1, 1);
                  end else begin
                     chk("coin_kind", mq[0][1:0], (i == 1) ? 2'b01 : 2'b10);
                     n_coin++;
                     if (n_coin > 1) chk("coin_retry_gap", since_fall, TIMEOUT);
                     chk("coin_attempt_limit", n_coin <= RETRIES + 1, 1);
                  end
               end
            end
            if (!drv[i] && drv_prev[i]) begin
               chk("pulse_len", run_len[i], PULSE_LEN);
               run_len[i] = 0;
               since_fall = 0;
            end
         end
         if (done) begin
            done_cnt++;
            last_done = cyc;
            chk("done_single_cycle", done_prev, 0);
            chk("done_has_req", mq.size() > 0, 1);
            if (mq.size() > 0) begin
               h = mq.pop_front();
               chk("done_prod_seen", n_prod > 0, h[2]);
               chk("done_coin_seen", n_coin > 0, h[1] ^ h[0]);
               done_log.push_back(h);
            end
            n_prod = 0;
            n_coin = 0;
         end
         if (req_valid && req_ready) begin
            mq.push_back({req_out, req_change});
            last_acc = cyc + 1;
         end
         drv_prev = drv;
         fault_prev = fault;
         done_prev = done;
      end
   end

   task automatic push(input logic [2:0] d);
      int n;
      n = 0;
      @(posedge clock); #1;
      req_valid = 1'b1;
      {req_out, req_change} = d;
      @(negedge clock);
      while (!req_ready && n < 400) begin @(negedge clock); n++; end
      if (!req_ready) chk("push_timeout", 0, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      int n;
      n = 0;
      while (done_cnt < target && n < limit) begin @(negedge clock); n++; end
      chk("wait_done_timeout", done_cnt >= target, 1);
      repeat (3) @(negedge clock);
   endtask

   int base_done, r0, r1, r2, base_log, k, n;
   logic acc;
   logic [2:0] list[6] = '{3'b100, 3'b101, 3'b110, 3'b011, 3'b010, 3'b001};

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_drives", drv, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_code", fault_code, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_ready", req_ready, 1);

      // Single product, no change
      resp_k = '{1, 1, 1};
      resp_dly = 10;
      base_done = done_cnt; r0 = rise_cnt[0]; r1 = rise_cnt[1]; r2 = rise_cnt[2];
      push(3'b100);
      wait_done(base_done + 1, 400);
      chk("t1_rise_lat", last_rise[0] - last_acc, 2);
      chk("t1_done_lat", last_done - last_acc, 19);
      chk("t1_prod_pulses", rise_cnt[0] - r0, 1);
      chk("t1_coin_pulses", (rise_cnt[1] - r1) + (rise_cnt[2] - r2), 0);
      chk("t1_busy_idle", busy, 0);

      // Product plus 5-coin
      base_done = done_cnt; r0 = rise_cnt[0]; r1 = rise_cnt[1]; r2 = rise_cnt[2];
      push(3'b101);
      wait_done(base_done + 1, 400);
      chk("t2a_done_lat", last_done - last_acc, 36);
      chk("t2a_prod", rise_cnt[0] - r0, 1);
      chk("t2a_coin5", rise_cnt[1] - r1, 1);
      chk("t2a_coin10", rise_cnt[2] - r2, 0);

      // 10-coin only
      base_done = done_cnt; r0 = rise_cnt[0]; r1 = rise_cnt[1]; r2 = rise_cnt[2];
      push(3'b010);
      wait_done(base_done + 1, 400);
      chk("t2b_done_lat", last_done - last_acc, 19);
      chk("t2b_prod", rise_cnt[0] - r0, 0);
      chk("t2b_coin5", rise_cnt[1] - r1, 0);
      chk("t2b_coin10", rise_cnt[2] - r2, 1);

      // Timeout, retries, fault, clear
      resp_k = '{0, 0, 0};
      base_done = done_cnt; r0 = rise_cnt[0];
      push(3'b100);
      n = 0;
      while (!fault && n < 400) begin @(negedge clock); n++; end
      repeat (5) @(negedge clock);
      chk("t3_fault", fault, 1);
      chk("t3_fault_code", fault_code, 1);
      chk("t3_ready", req_ready, 0);
      chk("t3_prod_pulses", rise_cnt[0] - r0, 3);
      chk("t3_third_rise", last_rise[0] - last_acc, 138);
      chk("t3_fault_lat", last_fault - last_acc, 206);
      @(posedge clock); #1 fault_clr = 1'b1;
      @(posedge clock); #1 fault_clr = 1'b0;
      @(negedge clock);
      chk("t3_fault_cleared", fault, 0);
      chk("t3_code_cleared", fault_code, 0);
      chk("t3_ready_back", req_ready, 1);
      chk("t3_busy_idle", busy, 0);
      chk("t3_no_done", done_cnt - base_done, 0);

      // Recovery on the second coin10 attempt
      resp_k = '{1, 1, 2};
      base_done = done_cnt; r2 = rise_cnt[2];
      push(3'b010);
      wait_done(base_done + 1, 400);
      chk("t4_done_lat", last_done - last_acc, 87);
      chk("t4_coin10_pulses", rise_cnt[2] - r2, 2);
      chk("t4_no_fault", fault, 0);

      // FIFO full with the first request stalled
      resp_k = '{0, 0, 0};
      base_done = done_cnt;
      base_log = done_log.size();
      k = 0;
      @(posedge clock); #1;
      req_valid = 1'b1;
      {req_out, req_change} = list[0];
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         acc = req_ready;
         @(posedge clock); #1;
         if (acc) begin
            k++;
            {req_out, req_change} = (k < 5) ? list[k] : list[5];
         end
      end
      @(negedge clock);
      chk("t5_accepts", k, 5);
      chk("t5_ready_low", req_ready, 0);
      @(posedge clock); #1 req_valid = 1'b0;
      resp_k = '{1, 1, 1};
      wait_done(base_done + 5, 2000);
      chk("t5_no_fault", fault, 0);
      chk("t5_log_size", done_log.size() - base_log, 5);
      for (int i = 0; i < 5; i++)
         if (base_log + i < done_log.size())
            chk("t5_order", done_log[base_log + i], list[i]);

      // Asynchronous reset in the middle of a product pulse
      resp_k = '{0, 0, 0};
      push(3'b100);
      n = 0;
      while (!prod_drive && n < 50) begin @(negedge clock); n++; end
      @(posedge clock); #1;
      chk("t6_drive_before", prod_drive, 1);
      #1 reset = 1'b0;
      #1;
      chk("t6_drive_dropped", prod_drive, 0);
      chk("t6_busy_cleared", busy, 0);
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock);
      chk("t6_ready", req_ready, 1);
      chk("t6_fifo_empty", busy, 0);
      base_done = done_cnt; r0 = rise_cnt[0]; r1 = rise_cnt[1]; r2 = rise_cnt[2];
      push(3'b000);
      wait_done(base_done + 1, 100);
      chk("t6_done_lat", last_done - last_acc, 2);
      chk("t6_no_drives", (rise_cnt[0] - r0) + (rise_cnt[1] - r1) + (rise_cnt[2] - r2), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
